// File: rtl/fire_pkg.sv
// Shared types and default sizes for the fire expand-1x1 weight path.
// Weight-vector and sequencer state types live here.
package fire_pkg;

  localparam int FIRE_WIDTH = 16;
  localparam int FIRE_ADDR  = 4;
  localparam int FIRE_NUM   = 64;
  localparam int FIRE_DEPTH = 16;
  localparam int FIRE_PIXW  = 16;

  typedef logic [FIRE_WIDTH-1:0] [0:FIRE_NUM-1] w_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

endpackage

// File: rtl/weight_fetch_seq.sv
// Weight ROM read sequencer: walks channels per pixel and streams
// the 64-wide weight vector to the expand MAC array.
module weight_fetch_seq
  import fire_pkg::*;
#(
  parameter int WIDTH = FIRE_WIDTH,
  parameter int ADDR  = FIRE_ADDR,
  parameter int NUM   = FIRE_NUM,
  parameter int DEPTH = FIRE_DEPTH,
  parameter int PIXW  = FIRE_PIXW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIXW-1:0]  pix_count,
  output logic [ADDR-1:0]  rom_addr,
  input  logic [WIDTH-1:0] rom_data [0:NUM-1],
  output logic [WIDTH-1:0] w_data [0:NUM-1],
  output logic             w_valid,
  input  logic             w_ready,
  output logic             w_last_ch,
  output logic             w_last,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDR-1:0] CH_LAST = ADDR'(DEPTH - 1);

  state_t          state;
  state_t          state_n;
  logic [ADDR-1:0] ch;
  logic [PIXW-1:0] pix;
  logic [PIXW-1:0] pix_cnt_q;

  logic load;
  logic hs;
  logic accept;
  logic zero_start;
  logic ch_last;
  logic pix_last;
  logic beat_last;

  assign hs        = w_valid & w_ready;
  assign ch_last   = (ch == CH_LAST);
  assign pix_last  = (pix == pix_cnt_q - PIXW'(1));
  assign beat_last = ch_last & pix_last;
  assign rom_addr  = ch;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    accept     = 1'b0;
    zero_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (pix_count != '0) begin
            accept  = 1'b1;
            state_n = FETCH;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      FETCH: begin
        load = ~w_valid | w_ready;
        if (load & beat_last) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Only the final beat can be in the register here.
        if (hs) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= zero_start | ((state == DRAIN) & hs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch        <= '0;
      pix       <= '0;
      pix_cnt_q <= '0;
    end else if (accept) begin
      ch        <= '0;
      pix       <= '0;
      pix_cnt_q <= pix_count;
    end else if (load) begin
      if (ch_last) begin
        ch  <= '0;
        pix <= pix + PIXW'(1);
      end else begin
        ch <= ch + ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM; j++) begin
        w_data[j] <= '0;
      end
      w_valid   <= 1'b0;
      w_last_ch <= 1'b0;
      w_last    <= 1'b0;
    end else if (load) begin
      w_data    <= rom_data;
      w_valid   <= 1'b1;
      w_last_ch <= ch_last;
      w_last    <= beat_last;
    end else if (hs) begin
      w_valid <= 1'b0;
    end
  end

endmodule
